road_badmask_builder: RTL and testbench

//  Upstream neighbour of the badmask-to-status mapper in the gigafitter track path.
//  - Consumes the per-road stream of SVX hit words, one word per handshake.
//  - Tracks which of the 5 layers delivered at least one good hit.
//  - At end-of-road, emits a 5-bit badmask (1 = layer unusable) plus a hit count

---
 rtl/gf_pkg.sv | 43 ++++
 rtl/sync_fifo_fwft.sv | 48 ++++
 rtl/road_badmask_builder.sv | 103 ++++++++++
 tb/tb_road_badmask_builder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared types and constants for the gigafitter road badmask path:
// the road record carried from the badmask builder to the mapper, and the
// badmask status codes the mapper derives from it.
package gf_pkg;

   localparam int NLAYERS = 5;
   localparam int LAYER_W = 3;
   localparam int CNT_W   = 4;

   // One finished road: per-layer unusable flags plus number of hit words.
   typedef struct packed {
      logic [NLAYERS-1:0] badmask;
      logic [CNT_W-1:0]   nhits;
   } road_rec_t;

   // Badmask patterns that mark the extremes of road quality.
   localparam logic [NLAYERS-1:0] BM_ALL_GOOD = '0;
   localparam logic [NLAYERS-1:0] BM_ALL_BAD  = '1;

   // Status codes shared with the mapper, keyed on how many layers are unusable.
   typedef enum logic [1:0] {
      BM_ST_OK       = 2'd0,   // every layer has a good hit
      BM_ST_ONE_BAD  = 2'd1,   // one layer missing, fit still possible
      BM_ST_TWO_BAD  = 2'd2,   // two layers missing, marginal fit
      BM_ST_UNUSABLE = 2'd3    // too few layers for a fit
   } bm_status_t;

   // Classify a badmask by the number of unusable layers.
   function automatic bm_status_t bm_status(input logic [NLAYERS-1:0] mask);
      int nbad;
      nbad = 0;
      for (int i = 0; i < NLAYERS; i++) begin
         if (mask[i]) nbad++;
      end
      case (nbad)
         0:       return BM_ST_OK;
         1:       return BM_ST_ONE_BAD;
         2:       return BM_ST_TWO_BAD;
         default: return BM_ST_UNUSABLE;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low; pointers carry an extra MSB so full and empty
// are distinguished without a separate counter.
module sync_fifo_fwft #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; only control state is reset, storage keeps stale data.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write at the current write slot.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/road_badmask_builder.sv
// Per-road badmask builder. Accumulates which layers saw a good hit and how
// many legal hit words arrived, then on the end-of-road word queues the
// inverted good mask and the hit count into an output FIFO for the mapper.
module road_badmask_builder
   import gf_pkg::*;
#(
   parameter int NLAYERS    = gf_pkg::NLAYERS,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = gf_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LAYER_W-1:0] in_layer,
   input  logic               in_bad,
   input  logic               in_eor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NLAYERS-1:0] out_badmask,
   output logic [CNT_W-1:0]   out_nhits,
   output logic               err_layer
);

   localparam int REC_W = NLAYERS + CNT_W;

   logic [NLAYERS-1:0] good_seen;
   logic [NLAYERS-1:0] good_seen_next;
   logic [NLAYERS-1:0] good_set;
   logic [CNT_W-1:0]   hit_cnt;
   logic [CNT_W-1:0]   hit_cnt_next;
   logic               accept;
   logic               hit_word;
   logic               bad_layer;
   logic               eor_word;
   logic               fifo_full;
   logic               fifo_empty;
   logic [REC_W-1:0]   push_rec;
   logic [REC_W-1:0]   head_rec;

   // Saturating increment so long noisy roads pin at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign in_ready  = !fifo_full;
   assign accept    = in_valid && in_ready;
   assign eor_word  = accept && in_eor;
   assign hit_word  = accept && !in_eor && (in_layer <= LAYER_W'(NLAYERS - 1));
   assign bad_layer = accept && !in_eor && (in_layer >  LAYER_W'(NLAYERS - 1));

   // One-hot layer decode, gated to good legal hits; bad hits only OR in zero.
   always_comb begin
      good_set = '0;
      for (int i = 0; i < NLAYERS; i++) begin
         if (hit_word && !in_bad && (in_layer == LAYER_W'(i))) good_set[i] = 1'b1;
      end
   end

   assign good_seen_next = good_seen | good_set;
   assign hit_cnt_next   = hit_word ? sat_inc(hit_cnt) : hit_cnt;
   assign push_rec       = {~good_seen_next, hit_cnt_next};

   // Road accumulators; an EOR word closes the road and restarts from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         good_seen <= '0;
         hit_cnt   <= '0;
      end else if (eor_word) begin
         good_seen <= '0;
         hit_cnt   <= '0;
      end else begin
         good_seen <= good_seen_next;
         hit_cnt   <= hit_cnt_next;
      end
   end

   // Sticky illegal-layer flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)            err_layer <= 1'b0;
      else if (bad_layer) err_layer <= 1'b1;
   end

   sync_fifo_fwft #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (eor_word),
      .wdata (push_rec),
      .pop   (out_ready),
      .rdata (head_rec),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // With nothing buffered the mapper sees an all-unusable, zero-hit road.
   assign out_valid   = !fifo_empty;
   assign out_badmask = fifo_empty ? {NLAYERS{1'b1}} : head_rec[REC_W-1:CNT_W];
   assign out_nhits   = fifo_empty ? '0 : head_rec[CNT_W-1:0];

endmodule

// File: tb/tb_road_badmask_builder.sv
// Directed bench for road_badmask_builder with a reference model of the road
// accumulators feeding a scoreboard queue of expected records.
module tb_road_badmask_builder;
   import gf_pkg::*;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [LAYER_W-1:0] in_layer;
   logic               in_bad;
   logic               in_eor;
   logic               out_valid;
   logic               out_ready;
   logic [NLAYERS-1:0] out_badmask;
   logic [CNT_W-1:0]   out_nhits;
   logic               err_layer;

   int nassert = 0;
   int nfail   = 0;

   road_rec_t          sb[$];
   logic [NLAYERS-1:0] m_good;
   logic [CNT_W-1:0]   m_cnt;

   road_badmask_builder #(
      .NLAYERS    (NLAYERS),
      .FIFO_DEPTH (4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_layer    (in_layer),
      .in_bad      (in_bad),
      .in_eor      (in_eor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_badmask (out_badmask),
      .out_nhits   (out_nhits),
      .err_layer   (err_layer)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one word for one cycle; update the model only if it was accepted.
   task automatic drive(input logic [LAYER_W-1:0] layer, input logic bad, input logic eor);
      logic acc;
      in_valid = 1'b1;
      in_layer = layer;
      in_bad   = bad;
      in_eor   = eor;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (acc) begin
         if (eor) begin
            sb.push_back('{badmask: ~m_good, nhits: m_cnt});
            m_good = '0;
            m_cnt  = '0;
         end else if (layer <= LAYER_W'(NLAYERS - 1)) begin
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (!bad) m_good[layer] = 1'b1;
         end
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("drain", sb.size(), 0);
   endtask

   // Scoreboard: a head seen with out_ready high at the falling edge pops next edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         road_rec_t e;
         nassert++;
         assert (sb.size() != 0) else begin
            nfail++;
            $error("FAIL unexpected_road: observed mask %0h nhits %0d expected none", out_badmask, out_nhits);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("road_badmask", out_badmask, e.badmask);
            chk("road_nhits", out_nhits, e.nhits);
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_layer = '0; in_bad = 1'b0; in_eor = 1'b0;
      out_ready = 1'b0; m_good = '0; m_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_badmask", out_badmask, 5'b11111);
      chk("rst_nhits", out_nhits, 0);
      chk("rst_err_layer", err_layer, 0);

      // All layers good; record visible right after the EOR edge.
      out_ready = 1'b1;
      for (int l = 0; l < 5; l++) drive(LAYER_W'(l), 1'b0, 1'b0);
      drive('0, 1'b0, 1'b1);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_badmask_head", out_badmask, 5'b00000);
      wait_drain();

      // Mixed good/bad hits; a bad hit never clears a good bit.
      drive(3'd1, 1'b0, 1'b0);
      drive(3'd3, 1'b1, 1'b0);
      drive(3'd3, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1);
      drive(3'd3, 1'b0, 1'b0);
      drive(3'd3, 1'b1, 1'b0);
      drive('0, 1'b0, 1'b1);
      wait_drain();

      // Fill the FIFO with empty roads, then drain in order.
      out_ready = 1'b0;
      for (int r = 0; r < 4; r++) drive('0, 1'b0, 1'b1);
      chk("t3_full_in_ready", in_ready, 0);
      drive('0, 1'b0, 1'b1);
      chk("t3_still_full", in_ready, 0);
      chk("t3_sb_depth", sb.size(), 4);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t3_ready_after_pop", in_ready, 1);
      wait_drain();

      // Count saturation and illegal layer handling.
      for (int h = 0; h < 20; h++) drive(3'd2, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b1);
      wait_drain();
      drive(3'd0, 1'b0, 1'b0);
      drive(3'd6, 1'b0, 1'b0);
      chk("t4_err_layer", err_layer, 1);
      drive('0, 1'b0, 1'b1);
      wait_drain();
      chk("t4_err_sticky", err_layer, 1);

      // Streaming roads through a shallow FIFO across several pointer wraps.
      for (int r = 0; r < 12; r++) begin
         drive(LAYER_W'(r % 5), 1'($urandom_range(0, 1)), 1'b0);
         drive('0, 1'b0, 1'b1);
      end
      wait_drain();

      // Reset with a partial road and buffered roads.
      out_ready = 1'b0;
      drive(3'd1, 1'b0, 1'b1);
      drive('0, 1'b0, 1'b1);
      drive(3'd2, 1'b0, 1'b0);
      drive(3'd3, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_good = '0;
      m_cnt  = '0;
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_err_cleared", err_layer, 0);
      chk("t6_badmask_empty", out_badmask, 5'b11111);
      out_ready = 1'b1;
      drive(3'd4, 1'b0, 1'b0);
      drive('0, 1'b0, 1'b1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
